// File: rtl/telemetry_mon_pkg.sv
// Shared definitions for the telemetry packet monitor.
// Holds the header byte values, the framing state enum, the packet length
// and small helpers used by the monitor datapath.
package telem_pkg;

  localparam logic [7:0] HDR0      = 8'hAA;
  localparam logic [7:0] HDR1      = 8'h55;
  localparam int         PKT_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR2 = 3'd1,
    B_HI = 3'd2,
    B_LO = 3'd3,
    C_HI = 3'd4,
    C_LO = 3'd5,
    T_HI = 3'd6,
    T_LO = 3'd7
  } telem_state_t;

  // High bytes of a 12-bit reading carry only a nibble; the top 4 bits must be 0.
  function automatic logic hi_nibble_ok(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/telemetry_mon_if.sv
// Byte stream from UART_rcv into the telemetry monitor.
//   rx_rdy  : byte available (UART_rcv.rdy)
//   rx_data : received byte
//   clr_rdy : byte consumed (UART_rcv.clr_rdy)
// master = UART receiver side, slave = monitor side.
interface telemetry_mon_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rdy;

  modport master (output rx_rdy, output rx_data, input clr_rdy);
  modport slave  (input rx_rdy, input rx_data, output clr_rdy);
endinterface

// File: rtl/telemetry_mon_gap_timer.sv
// Inter-byte timeout for the telemetry monitor.
//   clk, rst_n : clock, async active-low reset
//   run        : high while a packet is being framed
//   kick       : a byte is consumed this cycle (restarts the count)
//   expire     : the GAP_CYCLES-th idle cycle inside a packet, no byte present
// GAP_CYCLES must be at least 2.
module gap_timer #(
  parameter int GAP_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int                 CNT_W    = $clog2(GAP_CYCLES);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // A byte in the expiry cycle wins, so kick masks expire.
  assign expire = run && !kick && (cnt_r == LAST_CNT);

  // Idle-cycle counter: cleared outside a packet, on every byte and on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!run || kick || expire) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/telemetry_mon.sv
// Telemetry packet monitor downstream of UART_rcv.
// Frames AA 55 BATT_HI BATT_LO CURR_HI CURR_LO TORQ_HI TORQ_LO and commits
// the three 12-bit readings atomically with a one-cycle pkt_vld pulse.
//   clk, rst_n          : clock, async active-low reset
//   rx                  : byte stream (slave side), clr_rdy mirrors rx_rdy
//   batt/curr/torque    : last committed readings
//   pkt_vld             : pulse in the first cycle new readings are visible
//   in_sync             : set by a good packet, cleared by any error
//   pkt_cnt             : good packets, wrapping
//   err_cnt             : framing/timeout errors, saturating
module telemetry_mon
  import telem_pkg::*;
#(
  parameter int GAP_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  telemetry_mon_if.slave   rx,
  output logic [11:0]      batt,
  output logic [11:0]      curr,
  output logic [11:0]      torque,
  output logic             pkt_vld,
  output logic             in_sync,
  output logic [7:0]       pkt_cnt,
  output logic [7:0]       err_cnt
);

  telem_state_t state_r, state_nxt_s;
  logic         err_s;
  logic         commit_s;
  logic         expire_s;
  logic [11:0]  batt_sh_r;
  logic [11:0]  curr_sh_r;
  logic [3:0]   torq_hi_r;

  // Every byte offered is consumed the same cycle; no backpressure exists.
  assign rx.clr_rdy = rx.rx_rdy;

  gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_r != IDLE),
    .kick   (rx.rx_rdy),
    .expire (expire_s)
  );

  // Framing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus error/commit strobes.
  always_comb begin
    state_nxt_s = state_r;
    err_s       = 1'b0;
    commit_s    = 1'b0;
    if (rx.rx_rdy) begin
      case (state_r)
        // Garbage before a header is hunting, not an error.
        IDLE: begin
          if (rx.rx_data == HDR0) state_nxt_s = HDR2;
          else                    state_nxt_s = IDLE;
        end
        HDR2: begin
          if (rx.rx_data == HDR1) begin
            state_nxt_s = B_HI;
          end else if (rx.rx_data == HDR0) begin
            state_nxt_s = HDR2;
          end else begin
            state_nxt_s = IDLE;
            err_s       = 1'b1;
          end
        end
        B_HI, C_HI, T_HI: begin
          if (!hi_nibble_ok(rx.rx_data)) begin
            state_nxt_s = IDLE;
            err_s       = 1'b1;
          end else if (state_r == B_HI) begin
            state_nxt_s = B_LO;
          end else if (state_r == C_HI) begin
            state_nxt_s = C_LO;
          end else begin
            state_nxt_s = T_LO;
          end
        end
        B_LO:    state_nxt_s = C_HI;
        C_LO:    state_nxt_s = T_HI;
        T_LO: begin
          state_nxt_s = IDLE;
          commit_s    = 1'b1;
        end
        default: state_nxt_s = IDLE;
      endcase
    end else if (expire_s) begin
      state_nxt_s = IDLE;
      err_s       = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Shadow registers collect a packet; an abort discards the partial values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_sh_r <= 12'h000;
      curr_sh_r <= 12'h000;
      torq_hi_r <= 4'h0;
    end else if (err_s) begin
      batt_sh_r <= 12'h000;
      curr_sh_r <= 12'h000;
      torq_hi_r <= 4'h0;
    end else if (rx.rx_rdy) begin
      case (state_r)
        B_HI:    batt_sh_r[11:8] <= rx.rx_data[3:0];
        B_LO:    batt_sh_r[7:0]  <= rx.rx_data;
        C_HI:    curr_sh_r[11:8] <= rx.rx_data[3:0];
        C_LO:    curr_sh_r[7:0]  <= rx.rx_data;
        T_HI:    torq_hi_r       <= rx.rx_data[3:0];
        default: torq_hi_r       <= torq_hi_r;
      endcase
    end else begin
      torq_hi_r <= torq_hi_r;
    end
  end

  // Committed outputs, status and counters; torque low byte comes straight off the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt    <= 12'h000;
      curr    <= 12'h000;
      torque  <= 12'h000;
      pkt_vld <= 1'b0;
      in_sync <= 1'b0;
      pkt_cnt <= 8'd0;
      err_cnt <= 8'd0;
    end else begin
      pkt_vld <= commit_s;
      if (commit_s) begin
        batt    <= batt_sh_r;
        curr    <= curr_sh_r;
        torque  <= {torq_hi_r, rx.rx_data};
        pkt_cnt <= pkt_cnt + 8'd1;
        in_sync <= 1'b1;
      end else if (err_s) begin
        err_cnt <= sat_inc8(err_cnt);
        in_sync <= 1'b0;
      end else begin
        in_sync <= in_sync;
      end
    end
  end

endmodule

// File: tb/tb_telemetry_mon.sv
// Self-checking bench for telemetry_mon: expected readings are queued when
// the final byte of a good packet is driven and popped on each pkt_vld.
module tb_telemetry_mon;
  import telem_pkg::*;

  localparam int G = 16;

  typedef struct {
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] batt, curr, torque;
  logic        pkt_vld, in_sync;
  logic [7:0]  pkt_cnt, err_cnt;

  telemetry_mon_if rx_if ();

  telemetry_mon #(.GAP_CYCLES(G)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx_if),
    .batt    (batt),
    .curr    (curr),
    .torque  (torque),
    .pkt_vld (pkt_vld),
    .in_sync (in_sync),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   exp_pkt = 0;
  int   exp_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Scoreboard consumer: every pkt_vld pulse must match one queued packet.
  always @(negedge clk) begin
    if (rst_n && pkt_vld) begin
      if (sb_q.size() == 0) begin
        check_eq("pkt_vld_spurious", 32'(pkt_vld), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("batt", 32'(batt), 32'(mon_e.b));
        check_eq("curr", 32'(curr), 32'(mon_e.c));
        check_eq("torque", 32'(torque), 32'(mon_e.t));
      end
    end
  end

  task automatic idle(input int n);
    rx_if.rx_rdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_rdy  = 1'b1;
    rx_if.rx_data = b;
    #1;
    check_eq("clr_rdy", 32'(rx_if.clr_rdy), 32'd1);
    @(posedge clk);
    #1;
    rx_if.rx_rdy = 1'b0;
  endtask

  task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    logic [7:0] bytes [PKT_BYTES];
    exp_t e;
    bytes = '{HDR0, HDR1, {4'h0, b[11:8]}, b[7:0], {4'h0, c[11:8]}, c[7:0],
              {4'h0, t[11:8]}, t[7:0]};
    e.b = b; e.c = c; e.t = t;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (i == PKT_BYTES - 1) sb_q.push_back(e);
      send_byte(bytes[i]);
    end
    check_eq("vld_latency", 32'(pkt_vld), 32'd1);
    exp_pkt = (exp_pkt + 1) % 256;
  endtask

  task automatic check_status(input string tag, input logic exp_sync);
    check_eq({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check_eq({tag, "_in_sync"}, 32'(in_sync), 32'(exp_sync));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_if.rx_rdy = 1'b0;
    #3;
    check_eq("rst_batt", 32'(batt), 32'd0);
    check_eq("rst_curr", 32'(curr), 32'd0);
    check_eq("rst_torque", 32'(torque), 32'd0);
    check_eq("rst_pkt_vld", 32'(pkt_vld), 32'd0);
    check_eq("rst_in_sync", 32'(in_sync), 32'd0);
    check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pkt = 0;
    exp_err = 0;
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] garb [11];
    rst_n = 1'b0;
    rx_if.rx_rdy = 1'b0;
    rx_if.rx_data = 8'h00;
    #12;
    do_reset();
    check_eq("clr_rdy_idle", 32'(rx_if.clr_rdy), 32'd0);

    // Clean packet.
    send_pkt(12'hABC, 12'h123, 12'h7FF);
    idle(2);
    check_status("clean", 1'b1);

    // Leading garbage and header resync.
    garb = '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    for (int i = 0; i < 9; i++) send_byte(garb[i]);
    begin
      exp_t e;
      e.b = 12'h001; e.c = 12'h002; e.t = 12'h003;
      sb_q.push_back(e);
    end
    send_byte(garb[9]);
    exp_pkt++;
    idle(2);
    check_status("resync", 1'b1);

    // Bad high nibble aborts without touching the outputs.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1A);
    exp_err++;
    idle(2);
    check_status("badnib", 1'b0);
    check_eq("badnib_batt_hold", 32'(batt), 32'h001);
    check_eq("badnib_torque_hold", 32'(torque), 32'h003);
    send_pkt(12'h5A5, 12'h0F0, 12'hFFF);
    idle(2);
    check_status("after_badnib", 1'b1);

    // Timeout: one cycle short is still fine, the full gap errors.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    idle(G - 1);
    check_status("gap_minus1", 1'b1);
    idle(1);
    exp_err++;
    check_status("gap_expire", 1'b0);
    idle(2);

    // Byte landing exactly on the expiry cycle wins.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    idle(G - 1);
    send_byte(8'hBC); send_byte(8'h01); send_byte(8'h23); send_byte(8'h07);
    begin
      exp_t e;
      e.b = 12'hABC; e.c = 12'h123; e.t = 12'h7FF;
      sb_q.push_back(e);
    end
    send_byte(8'hFF);
    exp_pkt++;
    idle(2);
    check_status("gap_edge", 1'b1);

    // Packet counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++)
      send_pkt(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               12'($urandom_range(0, 4095)));
    idle(2);
    check_eq("pkt_cnt_255", 32'(pkt_cnt), 32'd255);
    send_pkt(12'h321, 12'h654, 12'h987);
    idle(2);
    check_eq("pkt_cnt_wrap", 32'(pkt_cnt), 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hAA); send_byte(8'h00);
      if (i == 253) begin
        idle(1);
        check_eq("err_cnt_254", 32'(err_cnt), 32'd254);
      end
    end
    idle(2);
    check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);
    check_eq("err_in_sync", 32'(in_sync), 32'd0);

    // Reset while waiting for the C_LO byte.
    send_pkt(12'h111, 12'h222, 12'h333);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h04);
    send_byte(8'h56); send_byte(8'h07);
    do_reset();
    send_pkt(12'h456, 12'h789, 12'h0AB);
    idle(2);
    check_status("post_reset", 1'b1);

    idle(3);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
